// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states and frame constants for the rx and tx sides.
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO with push/pop/full/empty/level; head entry is presented combinationally
// from registered storage and reads as zero while empty.
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_pushData,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [LVL_W-1:0] r_level;
    logic             w_doPush;
    logic             w_doPop;

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign o_empty  = (r_level == '0);
    assign o_full   = (r_level == FULL_LVL);
    assign w_doPop  = i_pop && !o_empty;
    assign w_doPush = i_push && (!o_full || w_doPop);
    assign o_level  = r_level;
    assign o_data   = o_empty ? '0 : r_mem[r_rdPtr];

    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_pushData;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fc.sv
// 16x-oversampling UART receiver with receive FIFO and registered RTS flow control.
// Defining UART_RX_PARITY_EN adds a parity bit (parity_odd / parity_err ports).
module uart_rx_fc
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int RTS_MARGIN = 2,
    parameter int DIV_W      = 16
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic                          rxd,
    output logic                          rts,
    output logic [UART_DATA_W-1:0]        out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          frame_err,
    output logic                          overrun,
`ifdef UART_RX_PARITY_EN
    input  logic                          parity_odd,
    output logic                          parity_err,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] MARGIN_L = LVL_W'(RTS_MARGIN);
    localparam logic [3:0]       MID_CNT  = 4'(UART_OVERSAMPLE / 2 - 1);
    localparam logic [3:0]       LAST_CNT = 4'(UART_OVERSAMPLE - 1);
    localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_W - 1);

    uart_rx_state_t r_state;
    uart_rx_state_t w_stateNext;

    logic                   r_rxdMeta;
    logic                   r_rxdSync;
    logic [DIV_W-1:0]       r_baudCnt;
    logic [3:0]             r_sampleCnt;
    logic [2:0]             r_bitCnt;
    logic [UART_DATA_W-1:0] r_shift;
    logic                   r_push;
    logic                   r_frameErr;
    logic                   r_overrun;
    logic                   r_rts;

    logic                   w_tick;
    logic                   w_shiftEn;
    logic                   w_bitClr;
    logic                   w_pushNext;
    logic                   w_frameErrNext;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_pop;
    logic [LVL_W-1:0]       w_level;

`ifdef UART_RX_PARITY_EN
    logic                   r_parityBad;
    logic                   r_parityErr;
    logic                   w_paritySample;
    logic                   w_parityErrNext;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rxdMeta <= 1'b1;
            r_rxdSync <= 1'b1;
        end else begin
            r_rxdMeta <= rxd;
            r_rxdSync <= r_rxdMeta;
        end
    end

    // Holding the divider at reload in IDLE aligns the tick phase to the start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_baudCnt <= '0;
        end else if (r_state == IDLE || r_baudCnt == '0) begin
            r_baudCnt <= baud_div;
        end else begin
            r_baudCnt <= r_baudCnt - 1'b1;
        end
    end

    assign w_tick = (r_state != IDLE) && (r_baudCnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext    = r_state;
        w_shiftEn      = 1'b0;
        w_bitClr       = 1'b0;
        w_pushNext     = 1'b0;
        w_frameErrNext = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_paritySample  = 1'b0;
        w_parityErrNext = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (!r_rxdSync) begin
                    w_stateNext = START;
                end
            end
            START: begin
                if (w_tick && r_sampleCnt == MID_CNT) begin
                    if (r_rxdSync) begin
                        w_stateNext = IDLE;
                    end else begin
                        w_bitClr    = 1'b1;
                        w_stateNext = DATA;
                    end
                end
            end
            DATA: begin
                if (w_tick && r_sampleCnt == LAST_CNT) begin
                    w_shiftEn = 1'b1;
                    if (r_bitCnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        w_stateNext = PARITY;
`else
                        w_stateNext = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (w_tick && r_sampleCnt == LAST_CNT) begin
                    w_paritySample = 1'b1;
                    w_stateNext    = STOP;
                end
            end
`endif
            STOP: begin
                if (w_tick && r_sampleCnt == LAST_CNT) begin
                    if (r_rxdSync) begin
`ifdef UART_RX_PARITY_EN
                        w_parityErrNext = r_parityBad;
                        w_pushNext      = !r_parityBad;
`else
                        w_pushNext      = 1'b1;
`endif
                        w_stateNext = IDLE;
                    end else begin
                        w_frameErrNext = 1'b1;
                        w_stateNext    = BREAK;
                    end
                end
            end
            BREAK: begin
                if (r_rxdSync) begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // The sample counter restarts on every state change and wraps 15->0 between data bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sampleCnt <= '0;
            r_bitCnt    <= '0;
            r_shift     <= '0;
        end else begin
            if (w_stateNext != r_state) begin
                r_sampleCnt <= '0;
            end else if (w_tick) begin
                r_sampleCnt <= r_sampleCnt + 1'b1;
            end
            if (w_bitClr) begin
                r_bitCnt <= '0;
            end else if (w_shiftEn) begin
                r_bitCnt <= r_bitCnt + 1'b1;
            end
            if (w_shiftEn) begin
                r_shift <= {r_rxdSync, r_shift[UART_DATA_W-1:1]};
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parityBad <= 1'b0;
            r_parityErr <= 1'b0;
        end else begin
            if (w_paritySample) begin
                r_parityBad <= (r_rxdSync != ((^r_shift) ^ parity_odd));
            end
            r_parityErr <= w_parityErrNext;
        end
    end

    assign parity_err = r_parityErr;
`endif

    assign w_pop = !w_empty && out_ready;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_W)
    ) rxFifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (r_push),
        .i_pushData (r_shift),
        .i_pop      (w_pop),
        .o_data     (out_data),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_level    (w_level)
    );

    // Overrun only when the FIFO cannot make room this cycle; RTS has no hysteresis.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_push     <= 1'b0;
            r_frameErr <= 1'b0;
            r_overrun  <= 1'b0;
            r_rts      <= 1'b0;
        end else begin
            r_push     <= w_pushNext;
            r_frameErr <= w_frameErrNext;
            r_overrun  <= r_push && w_full && !w_pop;
            r_rts      <= (DEPTH_L - w_level) > MARGIN_L;
        end
    end

    assign out_valid  = !w_empty;
    assign fifo_level = w_level;
    assign frame_err  = r_frameErr;
    assign overrun    = r_overrun;
    assign rts        = r_rts;

endmodule

// File: tb/tb_uart_rx_fc.sv
// Self-checking bench for uart_rx_fc: serial frames driven by a bench-side transmitter,
// received bytes scoreboarded against a queue of expected bytes.
module tb_uart_rx_fc;

    localparam int FIFO_DEPTH = 8;
    localparam int RTS_MARGIN = 2;
    localparam int DIV_W      = 16;
    localparam int BAUD_DIV   = 3;
    localparam int BIT_CYC    = 16 * (BAUD_DIV + 1);

    typedef struct {
        logic [7:0] data;
        logic       stopBit;
        int         holdLow;
        int         expBytes;
        int         expFrameErr;
    } rxVec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [DIV_W-1:0] baud_div;
    logic             rxd;
    logic             rts;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready;
    logic             frame_err;
    logic             overrun;
    logic [3:0]       fifo_level;

    int         nChecks     = 0;
    int         nFails      = 0;
    int         frameErrCnt = 0;
    int         overrunCnt  = 0;
    int         popCnt      = 0;
    int         maxLevel    = 0;
    int         prevLevel   = 0;
    logic       prevRst     = 1'b1;
    logic [7:0] expQ [$];
    logic [7:0] monExp;
    rxVec_t     vecs [6];
    logic       rndDone;

    uart_rx_fc #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .RTS_MARGIN (RTS_MARGIN),
        .DIV_W      (DIV_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .baud_div   (baud_div),
        .rxd        (rxd),
        .rts        (rts),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual != expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkRange(input string name, input int actual, input int lo, input int hi);
        nChecks++;
        if (actual < lo || actual > hi) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    task automatic timeoutFail(input string name);
        nChecks++;
        nFails++;
        $display("[TB] FAIL %s: timed out waiting on DUT", name);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sendFrame(input logic [7:0] data, input logic stopBit, input int holdLow);
        rxd = 1'b0;
        waitCycles(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            rxd = data[i];
            waitCycles(BIT_CYC);
        end
        rxd = stopBit;
        waitCycles(BIT_CYC);
        if (!stopBit && holdLow > 0) begin
            waitCycles(holdLow);
        end
        rxd = 1'b1;
    endtask

    task automatic applyStimulus(input rxVec_t v);
        sendFrame(v.data, v.stopBit, v.holdLow);
    endtask

    // Monitor: pulse counters, popped-byte scoreboard and the RTS rule from the previous level.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) frameErrCnt++;
            if (overrun) overrunCnt++;
            if (int'(fifo_level) > maxLevel) maxLevel = int'(fifo_level);
            if (out_valid && out_ready) begin
                popCnt++;
                if (expQ.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("[TB] FAIL pop_unexpected: got 0x%0h, expected no byte", out_data);
                end else begin
                    monExp = expQ.pop_front();
                    checkOutput("pop_data", int'(out_data), int'(monExp));
                end
            end
            if (!prevRst) begin
                checkOutput("rts_rule", int'(rts), ((FIFO_DEPTH - prevLevel) > RTS_MARGIN) ? 1 : 0);
            end
        end
        prevLevel = int'(fifo_level);
        prevRst   = rst;
    end

    initial begin
        int fe0;
        int ov0;
        int p0;
        int latency;
        int nGood;
        int nBad;
        logic [7:0] b;
        logic [7:0] partial;

        rxd       = 1'b1;
        out_ready = 1'b0;
        baud_div  = DIV_W'(BAUD_DIV);

        vecs[0] = '{data: 8'h3C, stopBit: 1'b0, holdLow: 200, expBytes: 0, expFrameErr: 1};
        vecs[1] = '{data: 8'h11, stopBit: 1'b1, holdLow: 0,   expBytes: 1, expFrameErr: 0};
        vecs[2] = '{data: 8'h00, stopBit: 1'b1, holdLow: 0,   expBytes: 1, expFrameErr: 0};
        vecs[3] = '{data: 8'hFF, stopBit: 1'b1, holdLow: 0,   expBytes: 1, expFrameErr: 0};
        vecs[4] = '{data: 8'h80, stopBit: 1'b0, holdLow: 0,   expBytes: 0, expFrameErr: 1};
        vecs[5] = '{data: 8'h01, stopBit: 1'b1, holdLow: 0,   expBytes: 1, expFrameErr: 0};

        waitCycles(4);
        checkOutput("reset_rts", int'(rts), 0);
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_out_data", int'(out_data), 0);
        checkOutput("reset_frame_err", int'(frame_err), 0);
        checkOutput("reset_overrun", int'(overrun), 0);
        checkOutput("reset_fifo_level", int'(fifo_level), 0);
        rst = 1'b0;
        waitCycles(2);
        checkOutput("rts_after_reset", int'(rts), 1);

        $display("[TB] single byte 0xA5");
        fe0 = frameErrCnt;
        expQ.push_back(8'hA5);
        latency = -1;
        fork
            sendFrame(8'hA5, 1'b1, 0);
            begin
                for (int i = 1; i <= BIT_CYC * 11; i++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        latency = i;
                        break;
                    end
                end
            end
        join
        if (latency < 0) timeoutFail("rx_a5_valid");
        else checkRange("rx_a5_latency", latency, 606, 616);
        checkOutput("rx_a5_data", int'(out_data), 8'hA5);
        checkOutput("rx_a5_valid", int'(out_valid), 1);
        checkOutput("rx_a5_frame_err", frameErrCnt - fe0, 0);
        p0 = popCnt;
        out_ready = 1'b1;
        waitCycles(3);
        out_ready = 1'b0;
        checkOutput("rx_a5_popped", popCnt - p0, 1);
        checkOutput("rx_a5_level_after", int'(fifo_level), 0);

        $display("[TB] glitch rejection");
        fe0 = frameErrCnt;
        rxd = 1'b0;
        waitCycles(20);
        rxd = 1'b1;
        waitCycles(200);
        checkOutput("glitch_level", int'(fifo_level), 0);
        checkOutput("glitch_valid", int'(out_valid), 0);
        checkOutput("glitch_frame_err", frameErrCnt - fe0, 0);

        $display("[TB] vector table");
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            fe0 = frameErrCnt;
            p0  = popCnt;
            if (vecs[i].expBytes != 0) expQ.push_back(vecs[i].data);
            applyStimulus(vecs[i]);
            waitCycles(40);
            checkOutput($sformatf("vec%0d_frame_err", i), frameErrCnt - fe0, vecs[i].expFrameErr);
            checkOutput($sformatf("vec%0d_bytes", i), popCnt - p0, vecs[i].expBytes);
        end

        $display("[TB] flow control and overrun");
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom_range(0, 255));
            expQ.push_back(b);
            sendFrame(b, 1'b1, 0);
            waitCycles(8);
            if (i == 4) begin
                checkOutput("fc_level5", int'(fifo_level), 5);
                checkOutput("fc_rts_level5", int'(rts), 1);
            end
            if (i == 5) begin
                checkOutput("fc_level6", int'(fifo_level), 6);
                checkOutput("fc_rts_level6", int'(rts), 0);
            end
        end
        checkOutput("fc_level_full", int'(fifo_level), 8);
        checkOutput("fc_rts_full", int'(rts), 0);
        ov0 = overrunCnt;
        sendFrame(8'hFF, 1'b1, 0);
        waitCycles(8);
        checkOutput("fc_overrun_pulse", overrunCnt - ov0, 1);
        checkOutput("fc_level_after_overrun", int'(fifo_level), 8);
        p0 = popCnt;
        out_ready = 1'b1;
        waitCycles(20);
        checkOutput("fc_drained", popCnt - p0, 8);
        checkOutput("fc_level_empty", int'(fifo_level), 0);
        checkOutput("fc_rts_recovered", int'(rts), 1);
        checkOutput("fc_queue_empty", expQ.size(), 0);

        $display("[TB] back-to-back frames");
        p0 = popCnt;
        maxLevel = 0;
        expQ.push_back(8'h00);
        expQ.push_back(8'hFF);
        expQ.push_back(8'h55);
        expQ.push_back(8'hAA);
        sendFrame(8'h00, 1'b1, 0);
        sendFrame(8'hFF, 1'b1, 0);
        sendFrame(8'h55, 1'b1, 0);
        sendFrame(8'hAA, 1'b1, 0);
        waitCycles(40);
        checkOutput("b2b_bytes", popCnt - p0, 4);
        checkOutput("b2b_max_level", maxLevel, 1);

        $display("[TB] reset mid-frame");
        out_ready = 1'b0;
        expQ.push_back(8'h5E);
        sendFrame(8'h5E, 1'b1, 0);
        waitCycles(8);
        checkOutput("rmf_level_before", int'(fifo_level), 1);
        fe0 = frameErrCnt;
        partial = 8'h77;
        rxd = 1'b0;
        waitCycles(BIT_CYC);
        for (int i = 0; i < 4; i++) begin
            rxd = partial[i];
            waitCycles(BIT_CYC);
        end
        rxd = partial[4];
        waitCycles(BIT_CYC / 2);
        rst = 1'b1;
        rxd = 1'b1;
        expQ.delete();
        waitCycles(3);
        checkOutput("rmf_out_valid", int'(out_valid), 0);
        checkOutput("rmf_out_data", int'(out_data), 0);
        checkOutput("rmf_level", int'(fifo_level), 0);
        checkOutput("rmf_rts", int'(rts), 0);
        checkOutput("rmf_frame_err", int'(frame_err), 0);
        checkOutput("rmf_overrun", int'(overrun), 0);
        rst = 1'b0;
        waitCycles(10);
        p0 = popCnt;
        out_ready = 1'b1;
        expQ.push_back(8'h12);
        sendFrame(8'h12, 1'b1, 0);
        waitCycles(40);
        checkOutput("rmf_bytes_after", popCnt - p0, 1);
        checkOutput("rmf_no_error", frameErrCnt - fe0, 0);

        $display("[TB] randomized frames");
        fe0 = frameErrCnt;
        p0 = popCnt;
        nGood = 0;
        nBad = 0;
        rndDone = 1'b0;
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    b = 8'($urandom_range(0, 255));
                    if ($urandom_range(0, 3) == 0) begin
                        nBad++;
                        sendFrame(b, 1'b0, $urandom_range(0, 100));
                    end else begin
                        nGood++;
                        expQ.push_back(b);
                        sendFrame(b, 1'b1, 0);
                    end
                    waitCycles($urandom_range(5, 60));
                end
                rndDone = 1'b1;
            end
            begin
                while (!rndDone) begin
                    out_ready = 1'($urandom_range(0, 1));
                    waitCycles(1);
                end
            end
        join
        out_ready = 1'b1;
        waitCycles(40);
        checkOutput("rnd_bytes", popCnt - p0, nGood);
        checkOutput("rnd_frame_errs", frameErrCnt - fe0, nBad);
        checkOutput("rnd_queue_empty", expQ.size(), 0);
        checkOutput("overrun_total", overrunCnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/uart_rx_fc.md
Name: uart_rx_fc

Overview:
- UART receiver for the sink end of a hardware-handshake UART link: deserialises 8N1 frames on `rxd` and drives `rts` flow control toward the remote transmitter.
- Received bytes land in a small FIFO, read out over a valid/ready stream.
- Sits between the chip pad/`uart_hw` link and on-chip consumers (debug/command controller).

Parameters:
- FIFO_DEPTH, 8, receive FIFO entries; power of two, at least 4.
- RTS_MARGIN, 2, `rts` deasserts when free entries ≤ RTS_MARGIN; range 1..FIFO_DEPTH-1.
- DIV_W, 16, width of the baud divisor input.

Ports:
- clk  input  1  single clock.
- rst  input  1  asynchronous, active-high reset.
- baud_div  input  DIV_W  clk cycles per 1/16 bit, minus 1; static while receiving.
- rxd  input  1  serial data from remote txd; asynchronous to clk.
- rts  output  1  1 = remote may send; 0 = stop sending.
- out_data  output  8  head-of-FIFO byte.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer accepts `out_data` when `out_valid & out_ready`.
- frame_err  output  1  1-cycle pulse: stop bit sampled low.
- overrun  output  1  1-cycle pulse: byte dropped because FIFO full.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset values: all outputs 0; `rts`=0 during reset, goes 1 on first clk edge after release (FIFO empty).
- `rxd` passes a 2-FF synchroniser, reset value 1, giving `rxd_s`. All sampling uses `rxd_s`.
- Tick generator: counter reloads `baud_div` and pulses `tick` on reaching 0. Counter is held reset in IDLE, so the first tick follows a start edge by exactly `baud_div`+1 cycles.
- Per-state sample counter, 0..15, advanced by `tick`.
- FSM:
  - IDLE: on `rxd_s`=0, go to START.
  - START: at 8th tick (mid-bit), if `rxd_s`=1 it is a false start, go to IDLE. Otherwise clear the bit counter and go to DATA.
  - DATA: every 16 ticks sample one bit into the shift register, LSB first. After bit 7 go to PARITY (when enabled) or STOP.
  - STOP: at 16th tick, sample.
    - `rxd_s`=1: push byte, go to IDLE.
    - `rxd_s`=0: pulse `frame_err`, discard byte, go to BREAK.
  - BREAK: wait for `rxd_s`=1, then go to IDLE. Holding the line low never produces a byte.
- Push timing:
  - Push occurs the cycle after the stop sample.
  - `out_valid` rises the following cycle (registered FIFO outputs).
- FIFO full at push: drop the new byte, pulse `overrun`, keep FIFO contents intact.
- Simultaneous push and pop:
  - Both occur; level is unchanged.
  - Full-FIFO push with same-cycle pop is accepted (no overrun).
- Flow control:
  - `rts` is registered.
  - `rts` = (FIFO_DEPTH − fifo_level) > RTS_MARGIN, evaluated each cycle.
  - No hysteresis.
  - Frames already in flight when `rts` falls are still received.
- Reset mid-frame: FSM to IDLE, FIFO emptied, partial byte lost; no error pulse.
- Pointer widths: $clog2(FIFO_DEPTH); wrap naturally. Level is one bit wider to distinguish full from empty.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - PARITY state follows DATA and samples the 9th bit at the 16th tick.
  - Even parity assumed; input `parity_odd` (1 bit) selects odd parity.
  - Mismatch pulses output `parity_err` for 1 cycle and the byte is discarded.
  - A frame error takes precedence: only `frame_err` pulses.
- Undefined:
  - No PARITY state.
  - Ports `parity_odd` and `parity_err` absent.
  - Frames are strictly 8N1.

Decomposition:
- Package `uart_pkg`:
  - FSM state enum `uart_rx_state_t` (IDLE, START, DATA, PARITY, STOP, BREAK).
  - Constants UART_DATA_W=8 and UART_OVERSAMPLE=16, shared with a future transmitter.
- Sub-module `uart_rx_fifo`:
  - Synchronous FIFO with push/pop/full/empty/level, parameter DEPTH.
  - Reusable by the transmit side.

Test Plan:
- Byte receive: baud_div=3 (64 clk/bit), send 0xA5 (8N1) → out_data=0xA5, out_valid=1 within 3 cycles of the stop-bit mid-sample; frame_err=0.
- Glitch rejection: baud_div=3, 20-cycle low pulse on rxd → no push, FSM back to IDLE, fifo_level=0.
- Framing error: send 0x3C with stop bit 0, line held low 200 cycles, then high → frame_err pulses once, no byte pushed; next 0x11 is received correctly.
- Flow control: FIFO_DEPTH=8, RTS_MARGIN=2, out_ready=0, send 6 bytes → rts falls after 6th push. Send 2 more → FIFO full. 9th byte (0xFF) → overrun pulse, FIFO holds first 8. Set out_ready=1 → 8 bytes drained in order, then rts=1.
- Back-to-back with simultaneous pop: out_ready=1, 4 consecutive frames 0x00, 0xFF, 0x55, 0xAA with no idle gap → all received in order, fifo_level ≤ 1 throughout.
- Reset mid-frame: assert rst during data bit 4 of 0x77 → outputs 0, FIFO empty. Release, then send 0x12 → only 0x12 received.
